// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED blink-rate sequencer.
package led_seq_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  // Rate codes as understood by the downstream blink block ({switch_1, switch_2}).
  localparam logic [IDX_W-1:0] RATE_100HZ = 2'd0;
  localparam logic [IDX_W-1:0] RATE_50HZ  = 2'd1;
  localparam logic [IDX_W-1:0] RATE_10HZ  = 2'd2;
  localparam logic [IDX_W-1:0] RATE_1HZ   = 2'd3;

endpackage

// File: rtl/led_blink_sequencer_button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new value has now been seen on DEBOUNCE_CYCLES consecutive samples.
  assign accept = (sync_p1 != level) && (cnt == CNT_LAST);

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= accept & sync_p1;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_blink_sequencer.sv
// Rate-select controller in front of the LED blink block.
// Manual mode passes the board switches through; auto mode walks the rate
// codes on a dwell timer, with a debounced button forcing an early step.
// Define LED_SEQ_PINGPONG_EN for 0,1,2,3,2,1,0,... ordering instead of wrap.
module led_blink_sequencer
  import led_seq_pkg::*;
#(
  parameter int DWELL_CYCLES    = 5000,
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_auto,
  input  logic             i_step_button,
  input  logic             i_switch_1,
  input  logic             i_switch_2,
  output logic             o_enable,
  output logic             o_switch_1,
  output logic             o_switch_2,
  output logic [IDX_W-1:0] o_sel_index,
  output logic             o_step_pulse
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic             en_p0, en_p1;
  logic             auto_p0, auto_p1;
  logic [IDX_W-1:0] sw_p0, sw_p1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, step_idx;
  logic [CNT_W-1:0] cnt_q;
  logic             enable_q, enable_d;
  logic             pulse_q;
  logic             advance;
  logic             press;
  logic             btn_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .button(i_step_button),
    .level (btn_level),
    .press (press)
  );

  // Two-flop synchronisers for the slow board controls.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_p0   <= 1'b0;
      en_p1   <= 1'b0;
      auto_p0 <= 1'b0;
      auto_p1 <= 1'b0;
      sw_p0   <= '0;
      sw_p1   <= '0;
    end else begin
      en_p0   <= i_enable;
      en_p1   <= en_p0;
      auto_p0 <= i_auto;
      auto_p1 <= auto_p0;
      sw_p0   <= {i_switch_1, i_switch_2};
      sw_p1   <= sw_p0;
    end
  end

`ifdef LED_SEQ_PINGPONG_EN
  logic dir_up_q;
  logic going_up;

  // Bounce off both ends; in between, keep the stored direction.
  always_comb begin
    going_up = (idx_q == RATE_100HZ) || ((idx_q != RATE_1HZ) && dir_up_q);
    step_idx = going_up ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
  end

  // Remember the direction of travel across advances.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dir_up_q <= 1'b1;
    end else if (advance) begin
      if (step_idx == RATE_1HZ)        dir_up_q <= 1'b0;
      else if (step_idx == RATE_100HZ) dir_up_q <= 1'b1;
      else                             dir_up_q <= going_up;
    end
  end
`else
  // Plain wrap-around ordering.
  always_comb begin
    step_idx = idx_q + IDX_W'(1);
  end
`endif

  // Mode state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_OFF;
    else            state_q <= state_d;
  end

  // Next mode from the synchronised controls, plus the advance decision.
  // The entry cycle into AUTO only restarts the dwell, it never advances.
  always_comb begin
    state_d = state_q;
    if (!en_p1)        state_d = ST_OFF;
    else if (!auto_p1) state_d = ST_MANUAL;
    else               state_d = ST_AUTO;
    enable_d = (state_d != ST_OFF);
    advance  = (state_d == ST_AUTO) && (state_q == ST_AUTO) &&
               (press || (cnt_q == DWELL_LAST));
  end

  // Index, dwell counter and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q    <= RATE_100HZ;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      pulse_q  <= advance;
      case (state_d)
        ST_MANUAL: begin
          idx_q <= sw_p1;
          cnt_q <= '0;
        end
        ST_AUTO: begin
          if (state_q != ST_AUTO) begin
            cnt_q <= '0;
          end else if (advance) begin
            idx_q <= step_idx;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign o_enable     = enable_q;
  assign o_sel_index  = idx_q;
  assign o_switch_1   = idx_q[1];
  assign o_switch_2   = idx_q[0];
  assign o_step_pulse = pulse_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed-with-random-parameters bench for led_blink_sequencer.
// Expected indices come from the advance count and the ordering rule.
module tb_led_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, en, auto_m, btn, sw1, sw2;
  logic       o_enable, o_switch_1, o_switch_2, o_step_pulse;
  logic [1:0] o_sel_index;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int p = 0;

  led_blink_sequencer dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_enable     (en),
    .i_auto       (auto_m),
    .i_step_button(btn),
    .i_switch_1   (sw1),
    .i_switch_2   (sw2),
    .o_enable     (o_enable),
    .o_switch_1   (o_switch_1),
    .o_switch_2   (o_switch_2),
    .o_sel_index  (o_sel_index),
    .o_step_pulse (o_step_pulse)
  );

  always #5 clk = ~clk;

  // Index after n auto advances starting from index 0.
  function automatic int exp_idx(input int n);
`ifdef LED_SEQ_PINGPONG_EN
    case (n % 6)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
`else
    return n % 4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Advance to the next falling edge and log any step pulse seen there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (o_step_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic wait_pulse(input int max, output bit got);
    int start;
    start = pulse_cnt;
    got = 1'b0;
    for (int n = 0; n < max; n++) begin
      step();
      if (pulse_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int r, g, t0, prev, pc0, cp, cp2, d, ts, last_edge, press_cyc, t_ch;
    bit got;

    // Reset held with every input high.
    rst_n = 1'b0; en = 1'b1; auto_m = 1'b1; btn = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    repeat (5) step();
    chk("reset_enable", o_enable, 0);
    chk("reset_sel", o_sel_index, 0);
    chk("reset_sw1", o_switch_1, 0);
    chk("reset_sw2", o_switch_2, 0);
    chk("reset_pulse", o_step_pulse, 0);

    // Release into manual with switches = 2.
    rst_n = 1'b1; auto_m = 1'b0; btn = 1'b0; sw1 = 1'b1; sw2 = 1'b0;
    repeat (4) step();
    chk("release_enable", o_enable, 1);
    chk("release_sel", o_sel_index, 2);

    // Manual mode follows random switch settings, never pulses.
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 3);
      sw1 = r[1]; sw2 = r[0];
      repeat (4) step();
      chk("manual_sel", o_sel_index, r);
      chk("manual_sw1", o_switch_1, r[1]);
      chk("manual_sw2", o_switch_2, r[0]);
    end
    chk("manual_no_pulse", pulse_cnt, 0);

    // Auto stepping from index 0 over seven dwells.
    sw1 = 1'b0; sw2 = 1'b0;
    repeat (4) step();
    chk("manual_zero", o_sel_index, 0);
    auto_m = 1'b1;
    t0 = cyc; prev = t0; p = 0;
    for (int k = 1; k <= 7; k++) begin
      wait_pulse(5100, got);
      chk("auto_pulse_seen", got, 1);
      if (k == 1) chk_rng("auto_first_dwell", last_pulse_cyc - t0, 5002, 5004);
      else        chk_rng("auto_dwell", last_pulse_cyc - prev, 4999, 5001);
      prev = last_pulse_cyc;
      p++;
      chk("auto_index", o_sel_index, exp_idx(p));
      chk("auto_sw1", o_switch_1, (exp_idx(p) >> 1) & 1);
      step();
      chk("auto_pulse_width", o_step_pulse, 0);
    end

    // Chatter, then a clean hold: exactly one press-driven advance.
    t_ch = cyc;
    while (cyc - t_ch < 100) begin
      btn = ~btn;
      g = $urandom_range(1, 3);
      repeat (g) step();
    end
    if (btn == 1'b1) begin
      btn = 1'b0;
      step();
    end
    btn = 1'b1;
    last_edge = cyc;
    pc0 = pulse_cnt;
    repeat (300) step();
    chk("debounce_one_press", pulse_cnt - pc0, 1);
    chk_rng("debounce_latency", last_pulse_cyc - last_edge, 252, 254);
    p++;
    chk("debounce_index", o_sel_index, exp_idx(p));
    press_cyc = last_pulse_cyc;
    btn = 1'b0;
    wait_pulse(5100, got);
    chk("dwell_after_press_seen", got, 1);
    chk_rng("dwell_after_press", last_pulse_cyc - press_cyc, 4999, 5001);
    p++;
    chk("dwell_after_press_index", o_sel_index, exp_idx(p));

    // Press lands on the same edge as dwell expiry: a single advance.
    cp = last_pulse_cyc;
    while (cyc < cp + 4747) step();
    btn = 1'b1;
    pc0 = pulse_cnt;
    while (cyc < cp + 5010) step();
    chk("simul_one_pulse", pulse_cnt - pc0, 1);
    chk_rng("simul_time", last_pulse_cyc - cp, 4999, 5001);
    p++;
    chk("simul_index", o_sel_index, exp_idx(p));
    btn = 1'b0;

    // Drop enable mid-dwell, then re-enable: full fresh dwell.
    cp2 = last_pulse_cyc;
    d = $urandom_range(1000, 3000);
    while (cyc < cp2 + d) step();
    en = 1'b0;
    pc0 = pulse_cnt;
    repeat (4) step();
    chk("off_enable", o_enable, 0);
    chk("off_hold_index", o_sel_index, exp_idx(p));
    repeat (6) step();
    chk("off_hold_index_late", o_sel_index, exp_idx(p));
    en = 1'b1;
    ts = cyc;
    repeat (4) step();
    chk("reenable_enable", o_enable, 1);
    wait_pulse(5100, got);
    chk("reenable_pulse_seen", got, 1);
    chk("reenable_single_pulse", pulse_cnt - pc0, 1);
    chk_rng("reenable_full_dwell", last_pulse_cyc - ts, 5002, 5004);
    p++;
    chk("reenable_index", o_sel_index, exp_idx(p));

    // Back to manual with switches = 3: index follows, no pulse.
    auto_m = 1'b0; sw1 = 1'b1; sw2 = 1'b1;
    pc0 = pulse_cnt;
    repeat (4) step();
    chk("to_manual_index", o_sel_index, 3);
    chk("to_manual_enable", o_enable, 1);
    repeat (20) step();
    chk("to_manual_no_pulse", pulse_cnt - pc0, 0);

    // Reset in the middle of a button hold in auto.
    auto_m = 1'b1; btn = 1'b1;
    repeat (200) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_enable", o_enable, 0);
    chk("midreset_sel", o_sel_index, 0);
    chk("midreset_pulse", o_step_pulse, 0);
    btn = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    pc0 = pulse_cnt;
    repeat (300) step();
    chk("postreset_no_pulse", pulse_cnt - pc0, 0);
    chk("postreset_index", o_sel_index, 0);
    chk("postreset_enable", o_enable, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
